smart_counter: RTL and testbench
================================

// Module: smart_counter
// PURPOSE
//   Loadable, enable-gated binary up-counter with synchronous reset.
//   Parallel load overrides counting. Wrap and zero status flags feed downstream
//   event/timeout logic.
//   Generic building block for timers, address generators and event counters.
// PARAMETERS
//   WIDTH      8      counter/load width in bits (>=2)
//   RESET_VAL  0      value q takes on reset (WIDTH bits)
// PORTS
//   clk       in   1      single clock; all state updates on rising edge
//   rst       in   1      synchronous, active-high reset
//   load      in   1      parallel load strobe
//   enable    in   1      count-enable; increment by 1 per cycle
//   load_val  in   WIDTH  value captured when load=1
//   q         out  WIDTH  registered counter value
//   wrap      out  1      registered; 1 for the cycle after q went all-ones -> 0 by counting
//   zero      out  1      combinational; 1 when q == 0
// BEHAVIOUR
//   - One clock (clk), synchronous active-high reset (rst); no async paths.
//   - Priority per rising edge: rst > load > enable > hold.
//       rst=1              : q <= RESET_VAL, wrap <= 0
//       else load=1        : q <= load_val, wrap <= 0 (enable ignored)
//       else enable=1      : q <= q + 1 mod 2^WIDTH; wrap <= (q == all-ones)
//       else               : q holds, wrap <= 0
//   - Reset values: q = RESET_VAL (0x00 default), wrap = 0, zero = (RESET_VAL==0).
//   - rst is sampled only at clk edges. Asserting rst between edges changes
//     nothing until the next rising edge. A rst pulse that misses every edge
//     has no effect.
//   - Latency: load/increment visible on q one cycle after the sampling edge.
//   - Wrap-around: all-ones + 1 -> 0, no saturation, no error. wrap pulses 1 cycle.
//   - Loading all-ones does not pulse wrap; only a counting transition does.
//   - Loading 0 sets zero=1 but does not pulse wrap.
//   - load with enable both high: loaded value wins; increment resumes next cycle.
//   - Inputs are assumed synchronous to clk; no internal synchronizers.
//   - Outputs are never X after the first reset edge. Before the first reset, q is
//     undefined and benches must reset first.
// TESTING
//   1. rst=1 for 2 edges, load_val=0xAA, load=0
//      -> q=0x00, zero=1, wrap=0; 0xAA never appears.
//   2. rst=0, load=1, load_val=0x3C for 1 edge, enable=0
//      -> q=0x3C next cycle; q holds 0x3C while enable=0.
//   3. From 0x3C, enable=1 for 5 edges -> q=0x3D,0x3E,0x3F,0x40,0x41;
//      enable=0 -> holds 0x41.
//   4. load=1, load_val=0xFE with enable=1 -> q=0xFE (not 0x42);
//      then load=0, enable=1 -> 0xFF, 0x00 with wrap=1 one cycle, zero=1,
//      then 0x01 with wrap=0.
//   5. Mid-count q=0x05, rst=1 across one edge with enable=1
//      -> q=0x00 at that edge, no increment. A rst pulse asserted and released
//      between edges -> q unaffected.
//   6. rst=1 and load=1 (load_val=0x77) on the same edge -> q=0x00.
//      After release, enable=1 for 4 edges -> 0x01..0x04.

Source files
------------

// File: rtl/smart_counter.sv
// Loadable, enable-gated binary up-counter with synchronous active-high reset.
// Registered wrap pulse on a counting roll-over; combinational zero flag.
module smart_counter #(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_q,
    output logic             o_wrap,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;

    // Priority: load > enable > hold (reset is applied in the register process).
    always_comb begin
        w_q_next    = r_q;
        w_wrap_next = 1'b0;
        if (i_load) begin
            w_q_next = i_load_val;
        end else if (i_enable) begin
            w_q_next    = r_q + WIDTH'(1);
            w_wrap_next = &r_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q    <= RESET_VAL;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign o_q    = r_q;
    assign o_wrap = r_wrap;
    assign o_zero = (r_q == '0);

endmodule

// File: tb/tb_smart_counter.sv
// Bench for smart_counter: directed vector table, a between-edge reset pulse,
// and randomized stimulus against an arithmetic reference model.
module tb_smart_counter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned MODV  = 1 << WIDTH;

    logic             clk;
    logic             rst;
    logic             load;
    logic             enable;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             wrap;
    logic             zero;

    int checks;
    int failures;

    smart_counter #(
        .WIDTH    (WIDTH),
        .RESET_VAL(8'h00)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_load    (load),
        .i_enable  (enable),
        .i_load_val(load_val),
        .o_q       (q),
        .o_wrap    (wrap),
        .o_zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             load;
        logic             enable;
        logic [WIDTH-1:0] load_val;
        logic [WIDTH-1:0] exp_q;
        logic             exp_wrap;
        logic             exp_zero;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [WIDTH-1:0] eq, input logic ew,
                             input logic ez);
        check({tag, ".q"}, 32'(q), 32'(eq));
        check({tag, ".wrap"}, 32'(wrap), 32'(ew));
        check({tag, ".zero"}, 32'(zero), 32'(ez));
    endtask

    // Apply inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic r, input logic l, input logic e, input logic [WIDTH-1:0] lv);
        rst      = r;
        load     = l;
        enable   = e;
        load_val = lv;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic l, input logic e, input logic [WIDTH-1:0] lv,
                       input logic [WIDTH-1:0] eq, input logic ew, input logic ez);
        vec_t v;
        v.rst = r; v.load = l; v.enable = e; v.load_val = lv;
        v.exp_q = eq; v.exp_wrap = ew; v.exp_zero = ez;
        vecs.push_back(v);
    endtask

    int          mq;
    bit          mw;
    logic        rr, rl, re;
    logic [WIDTH-1:0] rlv;

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b0; load = 1'b0; enable = 1'b0; load_val = '0;

        // Reset with a distracting load_val; 0xAA must never appear.
        add(1, 0, 0, 8'hAA, 8'h00, 0, 1);
        add(1, 0, 0, 8'hAA, 8'h00, 0, 1);
        // Load then hold.
        add(0, 1, 0, 8'h3C, 8'h3C, 0, 0);
        add(0, 0, 0, 8'h00, 8'h3C, 0, 0);
        add(0, 0, 0, 8'h00, 8'h3C, 0, 0);
        // Count 5, then hold.
        add(0, 0, 1, 8'h00, 8'h3D, 0, 0);
        add(0, 0, 1, 8'h00, 8'h3E, 0, 0);
        add(0, 0, 1, 8'h00, 8'h3F, 0, 0);
        add(0, 0, 1, 8'h00, 8'h40, 0, 0);
        add(0, 0, 1, 8'h00, 8'h41, 0, 0);
        add(0, 0, 0, 8'h00, 8'h41, 0, 0);
        // Load beats enable, then wrap.
        add(0, 1, 1, 8'hFE, 8'hFE, 0, 0);
        add(0, 0, 1, 8'h00, 8'hFF, 0, 0);
        add(0, 0, 1, 8'h00, 8'h00, 1, 1);
        add(0, 0, 1, 8'h00, 8'h01, 0, 0);
        // Loading all-ones or zero never pulses wrap.
        add(0, 1, 0, 8'hFF, 8'hFF, 0, 0);
        add(0, 1, 1, 8'h00, 8'h00, 0, 1);
        add(0, 0, 0, 8'h00, 8'h00, 0, 1);
        // Reset mid-count wins over enable.
        add(0, 1, 0, 8'h05, 8'h05, 0, 0);
        add(1, 0, 1, 8'h00, 8'h00, 0, 1);
        // Reset wins over load, then count 4.
        add(1, 1, 0, 8'h77, 8'h00, 0, 1);
        add(0, 0, 1, 8'h00, 8'h01, 0, 0);
        add(0, 0, 1, 8'h00, 8'h02, 0, 0);
        add(0, 0, 1, 8'h00, 8'h03, 0, 0);
        add(0, 0, 1, 8'h00, 8'h04, 0, 0);
        // Reset during a wrap cycle clears the pending pulse.
        add(0, 1, 0, 8'hFF, 8'hFF, 0, 0);
        add(1, 0, 1, 8'h00, 8'h00, 0, 1);

        @(negedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].load, vecs[i].enable, vecs[i].load_val);
            check_all($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_wrap, vecs[i].exp_zero);
        end

        // Reset pulse that misses every edge has no effect.
        step(0, 1, 0, 8'h05);
        check_all("pre_glitch", 8'h05, 0, 0);
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        step(0, 0, 0, 8'h00);
        check_all("rst_glitch_hold", 8'h05, 0, 0);
        step(0, 0, 1, 8'h00);
        check_all("rst_glitch_count", 8'h06, 0, 0);

        // Randomized run against the reference model.
        step(1, 0, 0, 8'h00);
        mq = 0;
        mw = 1'b0;
        check_all("rand_reset", 8'h00, 0, 1);
        for (int n = 0; n < 3000; n++) begin
            rr  = ($urandom_range(0, 31) == 0);
            rl  = ($urandom_range(0, 7) == 0);
            re  = ($urandom_range(0, 3) != 0);
            rlv = ($urandom_range(0, 2) == 0) ? WIDTH'(MODV - 1 - $urandom_range(0, 3))
                                              : WIDTH'($urandom);
            if (rr) begin
                mq = 0;
                mw = 1'b0;
            end else if (rl) begin
                mq = int'(rlv);
                mw = 1'b0;
            end else if (re) begin
                mw = (mq == MODV - 1);
                mq = (mq + 1) % MODV;
            end else begin
                mw = 1'b0;
            end
            step(rr, rl, re, rlv);
            check_all($sformatf("rand%0d", n), WIDTH'(mq), mw, mq == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
